// File: rtl/alu_op_sequencer_if.sv
// Bundle of the sequencer's instruction, load, ALU and status signals.
// The slave modport is the sequencer's view; the master modport is the
// view of whatever drives it (host plus ALU).
interface alu_op_sequencer_if #(
  parameter int DW = 16
);
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic          ld_en;
  logic [2:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_c;
  logic [2:0]    alu_opc;
  logic [DW-1:0] alu_w;
  logic          alu_zer;
  logic          alu_neg;
  logic          done;
  logic [DW-1:0] result;
  logic          flag_z;
  logic          flag_n;
  logic          busy;
  logic [2:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  modport slave (
    input  instr_valid, instr, ld_en, ld_addr, ld_data,
    input  alu_w, alu_zer, alu_neg, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_c, alu_opc,
    output done, result, flag_z, flag_n, busy, dbg_data
  );

  modport master (
    output instr_valid, instr, ld_en, ld_addr, ld_data,
    output alu_w, alu_zer, alu_neg, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_c, alu_opc,
    input  done, result, flag_z, flag_n, busy, dbg_data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Operand/issue stage in front of a combinational ALU. One instruction at a
// time walks IDLE -> READ -> EXEC -> WB; operands come from an internal
// register file that the host can also load and inspect.
module alu_op_sequencer #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input logic             clk,
  input logic             rst,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t        state;
  logic [DW-1:0] rf [NREG];
  // Only the instruction fields actually used are kept; bits [3:1] are spare.
  logic [2:0]    irOpc;
  logic [2:0]    irRd;
  logic [2:0]    irRs1;
  logic [2:0]    irRs2;
  logic          irCin;
  logic [DW-1:0] res;
  logic          resZ;
  logic          resN;

  // Handshake and status decode straight from the state register.
  assign bus.instr_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);

  // Debug port looks into the register file without any latency.
  assign bus.dbg_data = rf[bus.dbg_addr];

  // Sequencer FSM, register file and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      irOpc       <= '0;
      irRd        <= '0;
      irRs1       <= '0;
      irRs2       <= '0;
      irCin       <= 1'b0;
      res         <= '0;
      resZ        <= 1'b0;
      resN        <= 1'b0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_c   <= 1'b0;
      bus.alu_opc <= '0;
      bus.result  <= '0;
      bus.flag_z  <= 1'b0;
      bus.flag_n  <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          // Host load lands at the same edge as an accept, so READ sees it.
          if (bus.ld_en) rf[bus.ld_addr] <= bus.ld_data;
          if (bus.instr_valid) begin
            irOpc <= bus.instr[15:13];
            irRd  <= bus.instr[12:10];
            irRs1 <= bus.instr[9:7];
            irRs2 <= bus.instr[6:4];
            irCin <= bus.instr[0];
            state <= READ;
          end
        end
        READ: begin
          bus.alu_a   <= rf[irRs1];
          bus.alu_b   <= rf[irRs2];
          bus.alu_c   <= irCin;
          bus.alu_opc <= irOpc;
          state       <= EXEC;
        end
        EXEC: begin
          // ALU inputs have been stable all cycle; take its answer now.
          res      <= bus.alu_w;
          resZ     <= bus.alu_zer;
          resN     <= bus.alu_neg;
          bus.done <= 1'b1;
          state    <= WB;
        end
        WB: begin
          // Opcode 7 updates flags/result but never the register file.
          if (irOpc != 3'd7) rf[irRd] <= res;
          bus.result <= res;
          bus.flag_z <= resZ;
          bus.flag_n <= resN;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a small ALU stub, a transaction-level
// model (register array + latency counter) checked every cycle, and
// hand-computed literal expectations.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   doneCnt = 0;
  int   lastDoneCyc = 0;

  alu_op_sequencer_if #(.DW(16)) bus ();

  alu_op_sequencer #(.DW(16), .NREG(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ALU stub: 0 ~a+c, 1 a-b-!c style, 2 a+b+c, 3 xor, 4 and, 5 or, 6 byte pack, 7 zero
  function automatic logic [15:0] aluFn(logic [2:0] op, logic [15:0] a, logic [15:0] b, logic c);
    case (op)
      3'd0: return ~a + {15'd0, c};
      3'd1: return a + ~b + {15'd0, c};
      3'd2: return a + b + {15'd0, c};
      3'd3: return a ^ b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return {a[7:0], b[7:0]};
      default: return 16'h0000;
    endcase
  endfunction

  assign bus.alu_w   = aluFn(bus.alu_opc, bus.alu_a, bus.alu_b, bus.alu_c);
  assign bus.alu_zer = (bus.alu_w == 16'h0000);
  assign bus.alu_neg = bus.alu_w[15];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mRf [8];
  int          mAge = 0;          // cycles since acceptance, 0 = idle
  logic [15:0] mPendRes = '0;
  logic [2:0]  mPendRd = '0;
  logic        mPendWr = 1'b0;
  logic [15:0] mResult = '0;
  logic        mZ = 1'b0;
  logic        mN = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < 8; i++) mRf[i] = '0;
      mAge = 0; mResult = '0; mZ = 1'b0; mN = 1'b0;
    end else if (mAge == 0) begin
      if (bus.ld_en) mRf[bus.ld_addr] = bus.ld_data;
      if (bus.instr_valid) begin
        mPendRes = aluFn(bus.instr[15:13], mRf[bus.instr[9:7]], mRf[bus.instr[6:4]], bus.instr[0]);
        mPendRd  = bus.instr[12:10];
        mPendWr  = (bus.instr[15:13] != 3'd7);
        mAge = 1;
      end
    end else if (mAge < 3) begin
      mAge++;
    end else begin
      if (mPendWr) mRf[mPendRd] = mPendRes;
      mResult = mPendRes;
      mZ = (mPendRes == 16'h0000);
      mN = mPendRes[15];
      mAge = 0;
    end
  end

  // Per-cycle compare of every observable output against the model.
  always @(posedge clk) begin
    #1;
    chk("ready",  bus.instr_ready, mAge == 0);
    chk("busy",   bus.busy,        mAge != 0);
    chk("done",   bus.done,        mAge == 3);
    chk("result", bus.result,      mResult);
    chk("flagZ",  bus.flag_z,      mZ);
    chk("flagN",  bus.flag_n,      mN);
    chk("dbg",    bus.dbg_data,    mRf[bus.dbg_addr]);
    if (bus.done) begin
      doneCnt++;
      lastDoneCyc = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("idleTimeout", 1, 0);
  endtask

  task automatic load(logic [2:0] a, logic [15:0] d);
    waitIdle();
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  // Offer an instruction; returns the cycle number of the accepting edge.
  task automatic issue(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2,
                       logic cin, logic keep, output int acc);
    int n = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = {op, rd, rs1, rs2, 3'b000, cin};
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("acceptTimeout", 1, 0);
    @(posedge clk);
    #1 acc = cyc;
    if (!keep) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
    end
  endtask

  task automatic peek(string name, logic [2:0] a, logic [15:0] exp);
    @(negedge clk);
    bus.dbg_addr = a;
    #1 chk(name, bus.dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, dc;
    bus.instr_valid = 1'b0; bus.instr = '0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.dbg_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset mid-traffic: 2 cycles of rst while an op is in flight.
    load(3'd1, 16'h1234);
    issue(3'd2, 3'd3, 3'd1, 3'd1, 1'b0, 1'b0, acc);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rstReady", bus.instr_ready, 1);
    chk("rstBusy",  bus.busy, 0);
    chk("rstDone",  bus.done, 0);
    chk("rstFz",    bus.flag_z, 0);
    chk("rstFn",    bus.flag_n, 0);
    for (int i = 0; i < 8; i++) peek("rstRf", 3'(i), 16'h0000);

    // r3 = r1 + r2 + 1 = 9; done seen after edge T+2 (cycle T+3).
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    dc = doneCnt;
    issue(3'd2, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, acc);
    waitIdle();
    chk("addLat",   lastDoneCyc - acc, 2);
    chk("addDones", doneCnt - dc, 1);
    chk("addRes",   bus.result, 16'h0009);
    chk("addFz",    bus.flag_z, 0);
    chk("addFn",    bus.flag_n, 0);
    peek("addR3", 3'd3, 16'h0009);

    // r4 = ~r1 + 1 = 0xFFFB; r5 = r4 & r2 = 3; r6 = {r4.lo, r1.lo} = 0xFB05.
    issue(3'd0, 3'd4, 3'd1, 3'd0, 1'b1, 1'b0, acc);
    waitIdle();
    chk("negFn", bus.flag_n, 1);
    peek("negR4", 3'd4, 16'hFFFB);
    issue(3'd4, 3'd5, 3'd4, 3'd2, 1'b0, 1'b0, acc);
    waitIdle();
    peek("andR5", 3'd5, 16'h0003);
    issue(3'd6, 3'd6, 3'd4, 3'd1, 1'b0, 1'b0, acc);
    waitIdle();
    peek("packR6", 3'd6, 16'hFB05);

    // opc 7: no write-back, result 0, zero flag set, one done pulse.
    dc = doneCnt;
    issue(3'd7, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, acc);
    waitIdle();
    chk("nopDones", doneCnt - dc, 1);
    chk("nopRes",   bus.result, 16'h0000);
    chk("nopFz",    bus.flag_z, 1);
    chk("nopFn",    bus.flag_n, 0);
    peek("nopR1", 3'd1, 16'h0005);

    // Valid held high across two dependent ops: r3 = 8, r7 = r3 + r3 = 16.
    issue(3'd2, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, acc);
    issue(3'd2, 3'd7, 3'd3, 3'd3, 1'b0, 1'b0, acc2);
    chk("b2bGap", acc2 - acc, 4);
    waitIdle();
    peek("b2bR7", 3'd7, 16'h0010);

    // Load r2 in the same cycle an instruction using it is accepted.
    waitIdle();
    bus.ld_en = 1'b1; bus.ld_addr = 3'd2; bus.ld_data = 16'h0100;
    bus.instr_valid = 1'b1; bus.instr = {3'd2, 3'd3, 3'd1, 3'd2, 3'b000, 1'b0};
    @(negedge clk);
    bus.ld_en = 1'b0; bus.instr_valid = 1'b0;
    waitIdle();
    peek("ldAccR3", 3'd3, 16'h0105);

    // Reset during EXEC of an op targeting r3: no done, no write-back.
    dc = doneCnt;
    issue(3'd2, 3'd3, 3'd1, 3'd1, 1'b0, 1'b0, acc);  // returns at READ negedge
    @(negedge clk);                                  // EXEC
    rst = 1'b1;
    @(posedge clk);
    #1 chk("exRstReady", bus.instr_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("exRstDones", doneCnt - dc, 0);
    peek("exRstR3", 3'd3, 16'h0000);

    // ld_en while busy is ignored.
    load(3'd1, 16'h0007);
    issue(3'd2, 3'd6, 3'd1, 3'd1, 1'b0, 1'b0, acc);
    bus.ld_en = 1'b1; bus.ld_addr = 3'd5; bus.ld_data = 16'hAAAA;
    repeat (2) @(negedge clk);
    bus.ld_en = 1'b0;
    waitIdle();
    peek("busyLdR5", 3'd5, 16'h0000);
    peek("busyLdR6", 3'd6, 16'h000E);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
